// File: rtl/bitcell_array_ctrl.sv
// -----------------------------------------------------------------------------
// bitcell_array_ctrl
//
// Purpose:
//   Word-level request/response front end for a DEPTH x WIDTH array of
//   NAND-latch bitcells. It accepts one read or write at a time and walks the
//   asynchronous bitcell controls through SETUP -> STROBE -> HOLD (writes) or
//   SETUP -> STROBE -> RESP (reads). This keeps sel low whenever r_w or the
//   shared bit lines move. Read data is sampled from the shared tristate bus
//   and returned on a valid/ready response channel.
//
// Ports:
//   clk, rst                     clock (rising edge), synchronous active-high reset
//   req_valid/req_ready          request handshake
//   req_we/req_addr/req_wdata    request fields (1 = write)
//   rsp_valid/rsp_ready          read response handshake
//   rsp_rdata/rsp_err            read data, out-of-range address flag
//   cell_sel                     one-hot word select to the bitcell sel inputs
//   cell_r_w                     shared r_w to all bitcells (1 = write)
//   cell_in                      shared write bit lines
//   cell_out                     shared tristate read bus
// -----------------------------------------------------------------------------
module bitcell_array_ctrl #(
    parameter int WIDTH         = 8,
    parameter int DEPTH         = 4,
    parameter int ADDR_W        = 2,
    parameter int STROBE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WIDTH-1:0]  req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WIDTH-1:0]  rsp_rdata,
    output logic              rsp_err,
    output logic [DEPTH-1:0]  cell_sel,
    output logic              cell_r_w,
    output logic [WIDTH-1:0]  cell_in,
    input  logic [WIDTH-1:0]  cell_out
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        RESP
    } state_t;

    // Strobe counter value on the final sel-high cycle.
    localparam logic [3:0] LAST_CNT = 4'(STROBE_CYCLES - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DEPTH-1:0]  cell_sel_q, cell_sel_d;
    logic              cell_r_w_q, cell_r_w_d;
    logic [WIDTH-1:0]  cell_in_q, cell_in_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic              in_range;
    logic [DEPTH-1:0]  sel_onehot;

    assign req_ready = (state_q == IDLE) && !rst;

    // Address decode. An out-of-range address decodes to no select at all,
    // so the full sequence still runs but no cell is touched.
    always_comb begin
        in_range   = ({{(32-ADDR_W){1'b0}}, addr_q} < 32'(DEPTH));
        sel_onehot = '0;
        for (int i = 0; i < DEPTH; i++) begin
            sel_onehot[i] = (addr_q == ADDR_W'(i));
        end
    end

    // Next-state and registered-output logic. Each *_d value is what the
    // cell/response outputs must show during the state being entered, so
    // r_w and bit-line data always settle one cycle before sel rises and
    // stay put one cycle after it falls.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        cell_sel_d  = cell_sel_q;
        cell_r_w_d  = cell_r_w_q;
        cell_in_d   = cell_in_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            IDLE: begin
                cell_sel_d = '0;
                cell_r_w_d = 1'b0;
                if (req_valid && req_ready) begin
                    we_d       = req_we;
                    addr_d     = req_addr;
                    cell_r_w_d = req_we;
                    if (req_we) begin
                        cell_in_d = req_wdata;
                    end
                    state_d = SETUP;
                end
            end
            SETUP: begin
                cnt_d      = '0;
                cell_sel_d = sel_onehot;
                state_d    = STROBE;
            end
            STROBE: begin
                if (cnt_q == LAST_CNT) begin
                    cell_sel_d = '0;
                    if (we_q) begin
                        state_d = HOLD;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = in_range ? cell_out : '0;
                        rsp_err_d   = !in_range;
                        state_d     = RESP;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            HOLD: begin
                cell_r_w_d = 1'b0;
                state_d    = IDLE;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                cell_sel_d  = '0;
                cell_r_w_d  = 1'b0;
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and output registers; reset wins over any pending operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            cell_sel_q  <= '0;
            cell_r_w_q  <= 1'b0;
            cell_in_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            cell_sel_q  <= cell_sel_d;
            cell_r_w_q  <= cell_r_w_d;
            cell_in_q   <= cell_in_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign cell_sel  = cell_sel_q;
    assign cell_r_w  = cell_r_w_q;
    assign cell_in   = cell_in_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_bitcell_array_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bitcell_array_ctrl
//
// Two controllers share one clock:
//   unit 0 : DEPTH=4, STROBE_CYCLES=1
//   unit 1 : DEPTH=3, STROBE_CYCLES=4 (used for out-of-range and mid-strobe reset)
// Each controller drives a small behavioural bitcell array. A reference memory
// produces the expected read results. These are pushed to a per-unit queue
// when a read is issued, and popped when a response handshake occurs.
// -----------------------------------------------------------------------------
module tb_bitcell_array_ctrl;

    logic       clk = 1'b0;
    int         tests_run = 0;
    int         tests_failed = 0;

    logic       rst_a, req_valid_a, req_we_a, rsp_ready_a;
    logic [1:0] req_addr_a;
    logic [7:0] req_wdata_a;
    logic       req_ready_a, rsp_valid_a, rsp_err_a, cell_r_w_a;
    logic [7:0] rsp_rdata_a, cell_in_a, cell_out_a;
    logic [3:0] cell_sel_a;

    logic       rst_b, req_valid_b, req_we_b, rsp_ready_b;
    logic [1:0] req_addr_b;
    logic [7:0] req_wdata_b;
    logic       req_ready_b, rsp_valid_b, rsp_err_b, cell_r_w_b;
    logic [7:0] rsp_rdata_b, cell_in_b, cell_out_b;
    logic [2:0] cell_sel_b;

    logic [7:0] arr_a [4];
    logic [7:0] arr_b [3];
    logic [7:0] ref_a [4];
    logic [7:0] ref_b [4];
    logic [8:0] exp_qa [$];
    logic [8:0] exp_qb [$];
    logic       b_sel_seen = 1'b0;

    bitcell_array_ctrl #(.WIDTH(8), .DEPTH(4), .ADDR_W(2), .STROBE_CYCLES(1)) dut_a (
        .clk(clk), .rst(rst_a),
        .req_valid(req_valid_a), .req_ready(req_ready_a), .req_we(req_we_a),
        .req_addr(req_addr_a), .req_wdata(req_wdata_a),
        .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready_a),
        .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a),
        .cell_sel(cell_sel_a), .cell_r_w(cell_r_w_a),
        .cell_in(cell_in_a), .cell_out(cell_out_a)
    );

    bitcell_array_ctrl #(.WIDTH(8), .DEPTH(3), .ADDR_W(2), .STROBE_CYCLES(4)) dut_b (
        .clk(clk), .rst(rst_b),
        .req_valid(req_valid_b), .req_ready(req_ready_b), .req_we(req_we_b),
        .req_addr(req_addr_b), .req_wdata(req_wdata_b),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b),
        .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b),
        .cell_sel(cell_sel_b), .cell_r_w(cell_r_w_b),
        .cell_in(cell_in_b), .cell_out(cell_out_b)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    function automatic int selIdx(input logic [3:0] s);
        for (int i = 0; i < 4; i++) begin
            if (s[i]) return i;
        end
        return 0;
    endfunction

    // Behavioural bitcell arrays: a selected word drives the read bus when
    // r_w is low and latches the bit lines when r_w is high.
    assign cell_out_a = (cell_sel_a != 4'b0 && !cell_r_w_a) ? arr_a[selIdx(cell_sel_a)] : 8'bz;
    assign cell_out_b = (cell_sel_b != 3'b0 && !cell_r_w_b) ? arr_b[selIdx({1'b0, cell_sel_b})] : 8'bz;

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (cell_r_w_a && cell_sel_a[i]) arr_a[i] <= cell_in_a;
        end
        for (int i = 0; i < 3; i++) begin
            if (cell_r_w_b && cell_sel_b[i]) arr_b[i] <= cell_in_b;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Unit 0 monitor, a little after the falling edge: one-hot select,
    // no r_w/bit-line movement while a select is high, and scoreboard pops
    // on each response handshake.
    always begin
        logic       prev_rw;
        logic [7:0] prev_in;
        logic [8:0] e;
        @(negedge clk);
        #1;
        checkOutput("sel_onehot_a", 32'($countones(cell_sel_a) <= 1), 32'd1);
        if (cell_sel_a != 4'b0) begin
            checkOutput("sel_stable_a", 32'((cell_r_w_a === prev_rw) && (cell_in_a === prev_in)), 32'd1);
        end
        prev_rw = cell_r_w_a;
        prev_in = cell_in_a;
        if (rsp_valid_a && rsp_ready_a) begin
            if (exp_qa.size() == 0) begin
                checkOutput("rsp_unexpected_a", 32'(rsp_valid_a), 32'd0);
            end else begin
                e = exp_qa.pop_front();
                checkOutput("rsp_a", 32'({rsp_err_a, rsp_rdata_a}), 32'(e));
            end
        end
    end

    // Unit 1 monitor: same checks, and also records any select activity so
    // the out-of-range write can be checked for a silent bus.
    always begin
        logic       prev_rw;
        logic [7:0] prev_in;
        logic [8:0] e;
        @(negedge clk);
        #1;
        checkOutput("sel_onehot_b", 32'($countones(cell_sel_b) <= 1), 32'd1);
        if (cell_sel_b != 3'b0) begin
            b_sel_seen = 1'b1;
            checkOutput("sel_stable_b", 32'((cell_r_w_b === prev_rw) && (cell_in_b === prev_in)), 32'd1);
        end
        prev_rw = cell_r_w_b;
        prev_in = cell_in_b;
        if (rsp_valid_b && rsp_ready_b) begin
            if (exp_qb.size() == 0) begin
                checkOutput("rsp_unexpected_b", 32'(rsp_valid_b), 32'd0);
            end else begin
                e = exp_qb.pop_front();
                checkOutput("rsp_b", 32'({rsp_err_b, rsp_rdata_b}), 32'(e));
            end
        end
    end

    function automatic logic readyOf(input int u);
        return (u == 0) ? req_ready_a : req_ready_b;
    endfunction

    task automatic waitReady(input int u);
        int n = 0;
        while (!readyOf(u) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("ready_wait", 32'(readyOf(u)), 32'd1);
    endtask

    // Issue one request on a falling edge and push the expected read result.
    // Returns on the falling edge after the accepting rising edge.
    task automatic applyStimulus(input int u, input logic we, input logic [1:0] addr, input logic [7:0] wdata);
        waitReady(u);
        if (u == 0) begin
            req_valid_a = 1'b1; req_we_a = we; req_addr_a = addr; req_wdata_a = wdata;
            if (we) ref_a[addr] = wdata;
            else exp_qa.push_back({1'b0, ref_a[addr]});
        end else begin
            req_valid_b = 1'b1; req_we_b = we; req_addr_b = addr; req_wdata_b = wdata;
            if (we && addr < 2'd3) ref_b[addr] = wdata;
            else if (!we) exp_qb.push_back((addr < 2'd3) ? {1'b0, ref_b[addr]} : 9'h100);
        end
        @(negedge clk);
        if (u == 0) req_valid_a = 1'b0;
        else req_valid_b = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_qa.size() != 0 || exp_qb.size() != 0 || !req_ready_a || !req_ready_b) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drained", 32'(exp_qa.size() + exp_qb.size()), 32'd0);
    endtask

    initial begin
        int n;
        rst_a = 1'b1; rst_b = 1'b1;
        req_valid_a = 1'b1; req_we_a = 1'b1; req_addr_a = 2'd1; req_wdata_a = 8'h77;
        req_valid_b = 1'b0; req_we_b = 1'b0; req_addr_b = 2'd0; req_wdata_b = 8'h00;
        rsp_ready_a = 1'b1; rsp_ready_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ref_a[i] = 8'h00;
            ref_b[i] = 8'h00;
        end

        // Reset held two cycles with a request pending.
        repeat (2) begin
            @(negedge clk);
            checkOutput("rst_ready", 32'(req_ready_a), 32'd0);
            checkOutput("rst_sel", 32'(cell_sel_a), 32'd0);
            checkOutput("rst_rsp_valid", 32'(rsp_valid_a), 32'd0);
        end
        checkOutput("rst_outs", 32'({cell_r_w_a, cell_in_a, rsp_rdata_a, rsp_err_a}), 32'd0);
        req_valid_a = 1'b0;
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_rst_a", 32'(req_ready_a), 32'd1);
        checkOutput("ready_after_rst_b", 32'(req_ready_b), 32'd1);

        // Write addr 2 = A5, cycle by cycle.
        applyStimulus(0, 1'b1, 2'd2, 8'hA5);
        checkOutput("wr_setup", 32'({cell_sel_a, cell_r_w_a, cell_in_a}), 32'({4'b0000, 1'b1, 8'hA5}));
        @(negedge clk);
        checkOutput("wr_strobe", 32'({cell_sel_a, cell_r_w_a, cell_in_a}), 32'({4'b0100, 1'b1, 8'hA5}));
        @(negedge clk);
        checkOutput("wr_hold", 32'({cell_sel_a, cell_r_w_a, cell_in_a, req_ready_a}), 32'({4'b0000, 1'b1, 8'hA5, 1'b0}));
        @(negedge clk);
        checkOutput("wr_idle", 32'({cell_sel_a, cell_r_w_a, req_ready_a}), 32'({4'b0000, 1'b0, 1'b1}));

        // Read addr 2: response valid two edges after accept.
        applyStimulus(0, 1'b0, 2'd2, 8'h00);
        checkOutput("rd_lat0", 32'(rsp_valid_a), 32'd0);
        @(negedge clk);
        checkOutput("rd_lat1", 32'(rsp_valid_a), 32'd0);
        @(negedge clk);
        checkOutput("rd_lat2", 32'({rsp_valid_a, rsp_err_a, rsp_rdata_a}), 32'({1'b1, 1'b0, 8'hA5}));
        drain();

        // Back-to-back writes to every word, then read each one back.
        for (int i = 0; i < 4; i++) applyStimulus(0, 1'b1, 2'(i), 8'(1 << i));
        for (int i = 0; i < 4; i++) applyStimulus(0, 1'b0, 2'(i), 8'h00);
        drain();

        // Response backpressure on a read of addr 1.
        rsp_ready_a = 1'b0;
        applyStimulus(0, 1'b0, 2'd1, 8'h00);
        n = 0;
        while (!rsp_valid_a && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (5) begin
            checkOutput("bp_hold", 32'({rsp_valid_a, rsp_rdata_a, req_ready_a}), 32'({1'b1, 8'h02, 1'b0}));
            @(negedge clk);
        end
        rsp_ready_a = 1'b1;
        @(negedge clk);
        checkOutput("bp_release", 32'({rsp_valid_a, req_ready_a}), 32'({1'b0, 1'b1}));
        drain();

        // Unit 1: preload, out-of-range write, then read every address.
        applyStimulus(1, 1'b1, 2'd0, 8'h11);
        applyStimulus(1, 1'b1, 2'd1, 8'h22);
        applyStimulus(1, 1'b1, 2'd2, 8'h33);
        waitReady(1);
        b_sel_seen = 1'b0;
        applyStimulus(1, 1'b1, 2'd3, 8'hFF);
        waitReady(1);
        checkOutput("oor_wr_sel", 32'(b_sel_seen), 32'd0);
        for (int i = 0; i < 4; i++) applyStimulus(1, 1'b0, 2'(i), 8'h00);
        drain();

        // Reset during the second strobe cycle of a write to addr 0.
        applyStimulus(1, 1'b1, 2'd0, 8'hC3);
        @(negedge clk);
        checkOutput("mid_strobe1", 32'(cell_sel_b), 32'd1);
        @(negedge clk);
        checkOutput("mid_strobe2", 32'(cell_sel_b), 32'd1);
        rst_b = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_sel", 32'({cell_sel_b, rsp_valid_b, req_ready_b}), 32'd0);
        rst_b = 1'b0;
        repeat (6) begin
            @(negedge clk);
            checkOutput("mid_rst_norsp", 32'(rsp_valid_b), 32'd0);
        end
        applyStimulus(1, 1'b0, 2'd1, 8'h00);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/bitcell_array_ctrl.md
Name: bitcell_array_ctrl

Overview:
Synchronous controller that sits directly upstream of a DEPTH x WIDTH array of NAND-latch bitcells.
- Accepts word-level read/write requests on a valid/ready interface.
- Sequences the bitcells' asynchronous sel / r_w / in controls with explicit setup and hold cycles, so no latch sees a control glitch.
- Samples the shared tristate read bus and returns read data on a valid/ready response interface.

Parameters:
WIDTH, 8, bits per word (one bitcell per bit)
DEPTH, 4, number of words (one sel line per word)
ADDR_W, 2, address width; 2**ADDR_W >= DEPTH
STROBE_CYCLES, 1, cycles sel stays asserted per access; legal range 1..15

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active high
req_valid  input  1  request present
req_ready  output  1  controller can accept a request
req_we  input  1  1 = write, 0 = read
req_addr  input  ADDR_W  word address
req_wdata  input  WIDTH  write data
rsp_valid  output  1  read response present
rsp_ready  input  1  consumer accepts response
rsp_rdata  output  WIDTH  read data
rsp_err  output  1  read address was out of range
cell_sel  output  DEPTH  one-hot word select to bitcell sel inputs
cell_r_w  output  1  shared r_w to all bitcells (1 = write)
cell_in  output  WIDTH  shared bit-line write data, bit i to bitcell in of column i
cell_out  input  WIDTH  shared tristate read bus, bit i from all bitcell out of column i

Behaviour:
- One clock, synchronous active-high reset. Reset has priority over everything else.
- Reset values:
  - Registered outputs: cell_sel=0, cell_r_w=0, cell_in=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - State = IDLE.
  - req_ready=0 while rst is high.
- req_ready = (state==IDLE) && !rst. It is combinational from state and is never dependent on req_valid.
- Accept occurs on a rising edge with req_valid && req_ready. Request fields are captured into internal registers at that edge. Inputs are don't-care afterwards.
- States: IDLE, SETUP, STROBE, HOLD, RESP. All cell_* outputs are registered.
- IDLE:
  - cell_sel=0, cell_r_w=0, cell_in holds its last value.
  - On accept -> SETUP.
- SETUP (1 cycle):
  - cell_sel=0.
  - cell_r_w = captured we.
  - cell_in = captured wdata for writes; unchanged for reads.
  - -> STROBE.
- STROBE (STROBE_CYCLES cycles):
  - cell_sel = onehot(addr) if addr < DEPTH, else all 0.
  - cell_r_w and cell_in are held stable.
  - A 4-bit counter counts strobe cycles.
  - On the last cycle: writes -> HOLD; reads -> RESP.
- Read sampling: on the edge that ends the last STROBE cycle:
  - In range: rsp_rdata <= cell_out, rsp_err <= 0.
  - Out of range: rsp_rdata <= 0, rsp_err <= 1.
  - Z/X bits are captured as-is, with no masking.
- HOLD (writes only, 1 cycle):
  - cell_sel=0; cell_r_w=1 and cell_in are held, so data is stable after sel falls.
  - -> IDLE. cell_r_w returns to 0 in IDLE.
- RESP:
  - cell_sel=0, cell_r_w=0, rsp_valid=1.
  - rsp_rdata and rsp_err are held until rsp_valid && rsp_ready at an edge, then rsp_valid=0 and -> IDLE.
- Latency, with accept at edge E0 and P = STROBE_CYCLES:
  - Write: sel is high after E1 through E(1+P). req_ready is high again after E(2+P).
  - Read: rsp_valid is high after E(1+P). If rsp_ready is held high, req_ready is high after E(2+P).
  - A new request can be accepted only in IDLE. There is no pipelining and no overlap.
- Invariants:
  - cell_sel is never asserted in the same cycle that cell_r_w or cell_in changes.
  - At most one cell_sel bit is high at any time.
- Out-of-range write: the full sequence runs with cell_sel=0. No cell changes and no error is reported.
- Reset mid-operation:
  - cell_sel drops to 0 at the reset edge, and any pending response is dropped.
  - The content of the word being strobed during a write is undefined.
  - Other words are unaffected.
- Simultaneous rsp_ready and a new req_valid in RESP: the response completes; the request waits for IDLE, where req_ready is 1.

Test Plan:
- Reset: hold rst for 2 cycles with req_valid=1 -> req_ready=0, cell_sel=0, rsp_valid=0 throughout. req_ready=1 one cycle after rst falls.
- Write then read: write addr 2, data 8'hA5 (P=1) -> cell_sel=4'b0100 for exactly 1 cycle, preceded and followed by a cycle with sel=0 and cell_in=8'hA5. Read addr 2 -> rsp_rdata=8'hA5, rsp_err=0, rsp_valid 2 edges after accept.
- Back-to-back writes to all 4 addresses with distinct data (8'h01, 8'h02, 8'h04, 8'h08), then 4 reads -> each read returns its own data. cell_sel is never multi-hot and never overlaps a cell_in/cell_r_w change.
- Response backpressure: read addr 1 with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0. Raise rsp_ready -> rsp_valid falls after 1 edge and req_ready=1.
- Out of range (DEPTH=3, addr 3): write 8'hFF -> cell_sel stays 0 and stored words are unchanged. Read addr 3 -> rsp_rdata=0, rsp_err=1.
- Reset mid-strobe (P=4): assert rst during the 2nd STROBE cycle of a write to addr 0 -> cell_sel=0 at the next edge and no rsp_valid. A later read of addr 1 returns its previous value.
